// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler for two requesters sharing one pipelined bitwise logic datapath.
// Operations are issued onto registered datapath inputs, and a shadow valid/id/tag pipeline routes each result back.
module alu_issue_sched #(
    parameter int WIDTH  = 16,
    parameter int DP_LAT = 4,
    parameter int TAGW   = 3
) (
    input  logic             clkpos,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [TAGW-1:0]  req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [TAGW-1:0]  req1_tag,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic [1:0]       dp_op,
    input  logic [WIDTH-1:0] dp_out,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic [TAGW-1:0]  rsp_tag,
    output logic [3:0]       inflight,
    input  logic             hold
);

    // An entry reaches the last shadow stage in the cycle its result is on dp_out.
    localparam int LAST = DP_LAT;

    logic             grant0_s, grant1_s, issue_s, ret_s;
    logic [TAGW-1:0]  issue_tag_s;
    logic             rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic [1:0]       dp_op_q, dp_op_d;
    logic [LAST:0]    sh_vld_q;
    logic [LAST:0]    sh_id_q;
    logic [TAGW-1:0]  sh_tag_q [LAST+1];
    logic             rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;
    logic [3:0]       inflight_q, inflight_d;

    // Grant selection: the pointer only matters when both requesters contend.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (hold) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (req0_valid && req1_valid) begin
            grant0_s = ~rr_ptr_q;
            grant1_s = rr_ptr_q;
            rr_ptr_d = ~rr_ptr_q;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
    end

    assign issue_s     = grant0_s | grant1_s;
    assign issue_tag_s = grant1_s ? req1_tag : req0_tag;
    assign ret_s       = sh_vld_q[LAST];

    // Datapath operand capture; held when idle to avoid needless switching.
    always_comb begin
        dp_a_d  = dp_a_q;
        dp_b_d  = dp_b_q;
        dp_op_d = dp_op_q;
        if (grant1_s) begin
            dp_a_d  = req1_a;
            dp_b_d  = req1_b;
            dp_op_d = req1_op;
        end else if (grant0_s) begin
            dp_a_d  = req0_a;
            dp_b_d  = req0_b;
            dp_op_d = req0_op;
        end else begin
            dp_a_d  = dp_a_q;
            dp_b_d  = dp_b_q;
            dp_op_d = dp_op_q;
        end
    end

    // Response capture and routing to the originating requester.
    always_comb begin
        rsp0_d     = 1'b0;
        rsp1_d     = 1'b0;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        if (ret_s) begin
            rsp0_d     = ~sh_id_q[LAST];
            rsp1_d     = sh_id_q[LAST];
            rsp_data_d = dp_out;
            rsp_tag_d  = sh_tag_q[LAST];
        end else begin
            rsp0_d     = 1'b0;
            rsp1_d     = 1'b0;
        end
    end

    // Outstanding-operation count; an issue and a return in one cycle cancel.
    always_comb begin
        inflight_d = inflight_q;
        case ({issue_s, ret_s})
            2'b10:   inflight_d = inflight_q + 4'd1;
            2'b01:   inflight_d = inflight_q - 4'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Scheduler state, datapath inputs and response registers.
    always_ff @(posedge clkpos or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q   <= 1'b0;
            dp_a_q     <= {WIDTH{1'b0}};
            dp_b_q     <= {WIDTH{1'b0}};
            dp_op_q    <= 2'b00;
            rsp0_q     <= 1'b0;
            rsp1_q     <= 1'b0;
            rsp_data_q <= {WIDTH{1'b0}};
            rsp_tag_q  <= {TAGW{1'b0}};
            inflight_q <= 4'd0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            dp_a_q     <= dp_a_d;
            dp_b_q     <= dp_b_d;
            dp_op_q    <= dp_op_d;
            rsp0_q     <= rsp0_d;
            rsp1_q     <= rsp1_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
            inflight_q <= inflight_d;
        end
    end

    // Shadow pipeline shifts every cycle regardless of hold.
    always_ff @(posedge clkpos or negedge resetn) begin
        if (!resetn) begin
            sh_vld_q <= {(LAST+1){1'b0}};
            sh_id_q  <= {(LAST+1){1'b0}};
            for (int i = 0; i <= LAST; i++) begin
                sh_tag_q[i] <= {TAGW{1'b0}};
            end
        end else begin
            sh_vld_q[0] <= issue_s;
            sh_id_q[0]  <= grant1_s;
            sh_tag_q[0] <= issue_tag_s;
            for (int i = 1; i <= LAST; i++) begin
                sh_vld_q[i] <= sh_vld_q[i-1];
                sh_id_q[i]  <= sh_id_q[i-1];
                sh_tag_q[i] <= sh_tag_q[i-1];
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_op      = dp_op_q;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = rsp_tag_q;
    assign inflight   = inflight_q;

endmodule
